// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers the raster position from active-low syncs and locks after LOCK_FRAMES clean frames.
// Optional colour probe is built only when VGA_RX_PROBE_EN is defined.
module vga_sync_decoder #(
    parameter int H_LINE         = 800,
    parameter int V_LINE         = 525,
    parameter int H_SYNC_CYC     = 96,
    parameter int H_BACK_PORCH   = 48,
    parameter int H_ACTIVE_VIDEO = 640,
    parameter int V_SYNC_CYC     = 2,
    parameter int V_BACK_PORCH   = 33,
    parameter int V_ACTIVE_VIDEO = 480,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vgaHs,
    input  logic       vgaVs,
    input  logic [2:0] vgaR,
    input  logic [2:0] vgaG,
    input  logic [2:0] vgaB,
    input  logic [9:0] probe_x,
    input  logic [9:0] probe_y,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [7:0] err_count,
    output logic [8:0] probe_rgb
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [9:0] H_LAST = 10'(H_LINE - 1);
    localparam logic [9:0] V_LAST = 10'(V_LINE - 1);
    localparam logic [9:0] H_OFF  = 10'(H_SYNC_CYC + H_BACK_PORCH);
    localparam logic [9:0] V_OFF  = 10'(V_SYNC_CYC + V_BACK_PORCH);
    localparam logic [9:0] H_END  = 10'(H_SYNC_CYC + H_BACK_PORCH + H_ACTIVE_VIDEO);
    localparam logic [9:0] V_END  = 10'(V_SYNC_CYC + V_BACK_PORCH + V_ACTIVE_VIDEO);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    state_t     state, state_next;
    logic       hs_q, vs_q, hs_d, vs_d;
    logic [8:0] rgb_q;
    logic [9:0] h_cnt, v_cnt, h_cur, v_cur, px_cur, py_cur;
    logic [7:0] good_cnt, good_next;
    logic       vs_pending, line_bad_seen;
    logic       line_start, vs_fall, v_reset;
    logic       line_bad, frame_bad, frame_good, violation, in_active;

    // h_cur/v_cur are the counter values belonging to the sample currently in hs_q/vs_q/rgb_q.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        line_start = hs_d & ~hs_q;
        vs_fall    = vs_d & ~vs_q;
        v_reset    = line_start & (vs_pending | vs_fall);
        h_cur      = (h_cnt == 10'h3FF) ? h_cnt : h_cnt + 10'd1;
        if (line_start) h_cur = '0;
        v_cur = v_cnt;
        if (v_reset) v_cur = '0;
        else if (line_start && v_cnt != 10'h3FF) v_cur = v_cnt + 10'd1;
        line_bad   = line_start & (h_cnt != H_LAST);
        frame_bad  = v_reset & (v_cnt != V_LAST);
        frame_good = v_reset & ~frame_bad & ~line_bad & ~line_bad_seen;
        violation  = line_bad | frame_bad;
        px_cur     = h_cur - H_OFF;
        py_cur     = v_cur - V_OFF;
        in_active  = (state == LOCKED) && (h_cur >= H_OFF) && (h_cur < H_END)
                     && (v_cur >= V_OFF) && (v_cur < V_END);
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        unique case (state)
            SEARCH: begin
                if (v_reset) begin
                    state_next = ACQUIRE;
                    good_next  = '0;
                end
            end
            ACQUIRE: begin
                if (violation) begin
                    good_next = '0;
                end else if (frame_good) begin
                    good_next = good_cnt + 8'd1;
                    if (good_cnt + 8'd1 >= LOCK_N) state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (violation) begin
                    state_next = SEARCH;
                    good_next  = '0;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state         <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_d          <= 1'b1;
            vs_d          <= 1'b1;
            rgb_q         <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            good_cnt      <= '0;
            vs_pending    <= 1'b0;
            line_bad_seen <= 1'b0;
            err_count     <= '0;
            sync_err      <= 1'b0;
            locked        <= 1'b0;
            frame_start   <= 1'b0;
            pixel_valid   <= 1'b0;
            pixel_x       <= '0;
            pixel_y       <= '0;
        end else begin
            hs_q     <= vgaHs;
            vs_q     <= vgaVs;
            hs_d     <= hs_q;
            vs_d     <= vs_q;
            rgb_q    <= {vgaR, vgaG, vgaB};
            h_cnt    <= h_cur;
            v_cnt    <= v_cur;
            state    <= state_next;
            good_cnt <= good_next;

            if (v_reset)      vs_pending <= 1'b0;
            else if (vs_fall) vs_pending <= 1'b1;

            // The line ending at a frame boundary still belongs to the frame being judged.
            if (v_reset)       line_bad_seen <= 1'b0;
            else if (line_bad) line_bad_seen <= 1'b1;

            sync_err <= violation && (state != SEARCH);
            if (violation && state != SEARCH && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            locked      <= (state_next == LOCKED);
            frame_start <= v_reset && (state_next == LOCKED);
            pixel_valid <= in_active;
            if (in_active) begin
                pixel_x <= px_cur;
                pixel_y <= py_cur;
            end
        end
    end

`ifdef VGA_RX_PROBE_EN
    logic probe_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_rgb  <= '0;
            probe_done <= 1'b0;
        end else if (v_reset) begin
            probe_done <= 1'b0;
        end else if (in_active && !probe_done && px_cur == probe_x && py_cur == probe_y) begin
            probe_rgb  <= rgb_q;
            probe_done <= 1'b1;
        end
    end
`else
    logic unused_probe;
    assign unused_probe = ^{probe_x, probe_y, rgb_q};
    assign probe_rgb    = '0;
`endif

endmodule
